// File: rtl/mpr121_pkg.sv
// Shared constants, register defaults and target FSM state type for the MPR121 target emulator.
package mpr121_pkg;

    localparam logic [6:0] MPR121_ADDR    = 7'h5A;

    localparam logic [7:0] REG_TOUCH_LO   = 8'h00;
    localparam logic [7:0] REG_TOUCH_HI   = 8'h01;
    localparam logic [7:0] REG_AFE1       = 8'h5C;
    localparam logic [7:0] REG_AFE2       = 8'h5D;
    localparam logic [7:0] REG_ECR        = 8'h5E;
    localparam logic [7:0] REG_SOFT_RESET = 8'h80;

    localparam logic [7:0] SOFT_RESET_KEY = 8'h63;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK
    } i2c_tgt_state_t;

    function automatic logic [7:0] reg_default(input logic [7:0] addr);
        case (addr)
            REG_AFE1: return 8'h10;
            REG_AFE2: return 8'h24;
            default:  return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/mpr121_target_emulator_i2c_bus_sync.sv
// Two-flop synchronizers on SCL/SDA plus edge detection yielding SCL edges and START/STOP events.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda
);

    logic [1:0] pins;
    logic [1:0] sync_bus;
    logic [1:0] prev_bus;

    assign pins = {sda_in, scl_in};

    // Flops reset to 1 so an idle (pulled-up) bus produces no spurious edges after reset.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic meta_reg;
            logic sync_reg;
            logic prev_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                    prev_reg <= 1'b1;
                end else begin
                    meta_reg <= pins[gi];
                    sync_reg <= meta_reg;
                    prev_reg <= sync_reg;
                end
            end

            assign sync_bus[gi] = sync_reg;
            assign prev_bus[gi] = prev_reg;
        end
    endgenerate

    assign scl_rise  =  sync_bus[0] & ~prev_bus[0];
    assign scl_fall  = ~sync_bus[0] &  prev_bus[0];
    assign start_det =  sync_bus[0] &  prev_bus[0] &  prev_bus[1] & ~sync_bus[1];
    assign stop_det  =  sync_bus[0] &  prev_bus[0] & ~prev_bus[1] &  sync_bus[1];
    assign sda       =  sync_bus[1];

endmodule

// File: rtl/mpr121_target_emulator.sv
// I2C target presenting the MPR121 register map; touch status comes from touch_status_in.
// Define MPR121_IRQ_EN to add the active-low irq_n_out interrupt output.
module mpr121_target_emulator
    import mpr121_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR  = MPR121_ADDR,
    parameter int         REG_COUNT = 128
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe_out,
    input  logic [11:0] touch_status_in,
    output logic        reg_wr_valid_out,
    output logic [7:0]  reg_wr_addr_out,
    output logic [7:0]  reg_wr_data_out,
    output logic        busy_out
`ifdef MPR121_IRQ_EN
    ,
    output logic        irq_n_out
`endif
);

    localparam int AW = $clog2(REG_COUNT);

    logic scl_rise, scl_fall, start_det, stop_det, sda_sync;

    i2c_bus_sync u_bus_sync (
        .clk       (clk_in),
        .rst       (rst_in),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda       (sda_sync)
    );

    i2c_tgt_state_t state_reg, state_next;
    logic [3:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  shift_reg, shift_next;
    logic [7:0]  tx_reg, tx_next;
    logic [7:0]  ptr_reg, ptr_next;
    logic        sda_oe_reg, sda_oe_next;
    logic        ack_phase_reg, ack_phase_next;
    logic        rw_reg, rw_next;
    logic [11:0] snapshot_reg;
    logic        reg_wr_valid_reg;
    logic [7:0]  reg_wr_addr_reg, reg_wr_data_reg;
    logic [7:0]  regs_reg [REG_COUNT];

    logic [7:0] rx_byte;
    logic [7:0] rd_value;
    logic       ptr_in_range;
    logic       wr_commit, tx_load;
    logic       soft_reset, reg_write, wr_strobe;

    assign rx_byte      = {shift_reg[6:0], sda_sync};
    assign ptr_in_range = ({1'b0, ptr_reg} < 9'(REG_COUNT));
    assign soft_reset   = wr_commit && (ptr_reg == REG_SOFT_RESET) && (rx_byte == SOFT_RESET_KEY);
    assign reg_write    = wr_commit && ptr_in_range && !soft_reset
                          && (ptr_reg != REG_TOUCH_LO) && (ptr_reg != REG_TOUCH_HI);
    assign wr_strobe    = wr_commit && (ptr_in_range || soft_reset);

    always_comb begin
        rd_value = 8'h00;
        if (ptr_reg == REG_TOUCH_LO)
            rd_value = snapshot_reg[7:0];
        else if (ptr_reg == REG_TOUCH_HI)
            rd_value = {4'b0000, snapshot_reg[11:8]};
        else if (ptr_in_range)
            rd_value = regs_reg[ptr_reg[AW-1:0]];
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        tx_next        = tx_reg;
        ptr_next       = ptr_reg;
        sda_oe_next    = sda_oe_reg;
        ack_phase_next = ack_phase_reg;
        rw_next        = rw_reg;
        wr_commit      = 1'b0;
        tx_load        = 1'b0;

        if (start_det) begin
            state_next     = ST_ADDR;
            bit_cnt_next   = 4'd0;
            ack_phase_next = 1'b0;
            sda_oe_next    = 1'b0;
        end else if (stop_det) begin
            state_next  = ST_IDLE;
            sda_oe_next = 1'b0;
        end else begin
            case (state_reg)
                ST_ADDR, ST_PTR, ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_next   = rx_byte;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            ack_phase_next = 1'b0;
                            if (state_reg == ST_ADDR) begin
                                if (rx_byte[7:1] == I2C_ADDR) begin
                                    state_next = ST_ADDR_ACK;
                                    rw_next    = rx_byte[0];
                                end else begin
                                    state_next = ST_IDLE;
                                end
                            end else if (state_reg == ST_PTR) begin
                                ptr_next   = rx_byte;
                                state_next = ST_PTR_ACK;
                            end else begin
                                wr_commit  = 1'b1;
                                ptr_next   = ptr_reg + 8'd1;
                                state_next = ST_WR_ACK;
                            end
                        end
                    end
                end

                // First SCL fall pulls SDA for the ACK slot, second fall ends the 9th clock.
                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_reg) begin
                            sda_oe_next    = 1'b1;
                            ack_phase_next = 1'b1;
                        end else begin
                            ack_phase_next = 1'b0;
                            bit_cnt_next   = 4'd0;
                            sda_oe_next    = 1'b0;
                            if (state_reg == ST_ADDR_ACK && rw_reg) begin
                                tx_load     = 1'b1;
                                tx_next     = rd_value;
                                sda_oe_next = ~rd_value[7];
                                state_next  = ST_RD_DATA;
                            end else if (state_reg == ST_ADDR_ACK) begin
                                state_next = ST_PTR;
                            end else begin
                                state_next = ST_WR_DATA;
                            end
                        end
                    end
                end

                ST_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_reg == 4'd8) begin
                            sda_oe_next    = 1'b0;
                            ack_phase_next = 1'b0;
                            state_next     = ST_RD_ACK;
                        end else begin
                            tx_next     = {tx_reg[6:0], 1'b0};
                            sda_oe_next = ~tx_reg[6];
                        end
                    end
                end

                ST_RD_ACK: begin
                    if (scl_rise && !ack_phase_reg) begin
                        if (!sda_sync) begin
                            ptr_next       = ptr_reg + 8'd1;
                            ack_phase_next = 1'b1;
                        end else begin
                            sda_oe_next = 1'b0;
                            state_next  = ST_IDLE;
                        end
                    end else if (scl_fall && ack_phase_reg) begin
                        tx_load        = 1'b1;
                        tx_next        = rd_value;
                        sda_oe_next    = ~rd_value[7];
                        bit_cnt_next   = 4'd0;
                        ack_phase_next = 1'b0;
                        state_next     = ST_RD_DATA;
                    end
                end

                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg        <= ST_IDLE;
            bit_cnt_reg      <= 4'd0;
            shift_reg        <= 8'h00;
            tx_reg           <= 8'h00;
            ptr_reg          <= 8'h00;
            sda_oe_reg       <= 1'b0;
            ack_phase_reg    <= 1'b0;
            rw_reg           <= 1'b0;
            snapshot_reg     <= 12'h000;
            reg_wr_valid_reg <= 1'b0;
            reg_wr_addr_reg  <= 8'h00;
            reg_wr_data_reg  <= 8'h00;
        end else begin
            state_reg        <= state_next;
            bit_cnt_reg      <= bit_cnt_next;
            shift_reg        <= shift_next;
            tx_reg           <= tx_next;
            ptr_reg          <= ptr_next;
            sda_oe_reg       <= sda_oe_next;
            ack_phase_reg    <= ack_phase_next;
            rw_reg           <= rw_next;
            reg_wr_valid_reg <= wr_strobe;
            // Latching on every START keeps a multi-byte status read coherent.
            if (start_det)
                snapshot_reg <= touch_status_in;
            if (wr_strobe) begin
                reg_wr_addr_reg <= ptr_reg;
                reg_wr_data_reg <= rx_byte;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_COUNT; i++)
                regs_reg[i] <= reg_default(8'(i));
        end else if (soft_reset) begin
            for (int i = 0; i < REG_COUNT; i++)
                regs_reg[i] <= reg_default(8'(i));
        end else if (reg_write) begin
            regs_reg[ptr_reg[AW-1:0]] <= rx_byte;
        end
    end

`ifdef MPR121_IRQ_EN
    logic [11:0] last_read_reg;
    logic        irq_n_reg;
    logic        irq_clear;

    assign irq_clear = tx_load && ((ptr_reg == REG_TOUCH_LO) || (ptr_reg == REG_TOUCH_HI));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            last_read_reg <= 12'h000;
            irq_n_reg     <= 1'b1;
        end else if (irq_clear) begin
            last_read_reg <= snapshot_reg;
            irq_n_reg     <= 1'b1;
        end else if (touch_status_in != last_read_reg) begin
            irq_n_reg <= 1'b0;
        end
    end

    assign irq_n_out = irq_n_reg;
`endif

    assign sda_oe_out       = sda_oe_reg;
    assign busy_out         = (state_reg != ST_IDLE) && (state_reg != ST_ADDR);
    assign reg_wr_valid_out = reg_wr_valid_reg;
    assign reg_wr_addr_out  = reg_wr_addr_reg;
    assign reg_wr_data_out  = reg_wr_data_reg;

endmodule

// File: tb/tb_mpr121_target_emulator.sv
// Scoreboard bench: a bit-banged I2C controller drives the emulator; ACKs, read bytes and write strobes are checked.
`timescale 1ns/1ps
module tb_mpr121_target_emulator;

    localparam int Q = 50;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        scl    = 1'b1;
    logic        sda_drv = 1'b1;
    logic [11:0] touch_status_in = 12'h000;
    logic        sda_oe_out;
    logic        reg_wr_valid_out;
    logic [7:0]  reg_wr_addr_out;
    logic [7:0]  reg_wr_data_out;
    logic        busy_out;
    logic        sda_line;
`ifdef MPR121_IRQ_EN
    logic        irq_n_out;
`endif

    assign sda_line = sda_drv & ~sda_oe_out;

    mpr121_target_emulator dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .scl_in           (scl),
        .sda_in           (sda_line),
        .sda_oe_out       (sda_oe_out),
        .touch_status_in  (touch_status_in),
        .reg_wr_valid_out (reg_wr_valid_out),
        .reg_wr_addr_out  (reg_wr_addr_out),
        .reg_wr_data_out  (reg_wr_data_out),
        .busy_out         (busy_out)
`ifdef MPR121_IRQ_EN
        ,
        .irq_n_out        (irq_n_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] wr_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic        mon_en   = 1'b0;
    logic        saw_oe   = 1'b0;
    logic        saw_busy = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sb_pop(input logic [15:0] got);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 16'(exp_q.size()), 16'd1);
        end else begin
            e = exp_q.pop_front();
            check(e.tag, got, e.val);
            $display("txn %s got=%h", e.tag, got);
        end
    endtask

    // Strobe monitor: every accepted write must match the next expected {addr,data}.
    always @(negedge clk_in) begin
        if (reg_wr_valid_out) begin
            if (wr_q.size() == 0)
                check("wr_unexpected", {reg_wr_addr_out, reg_wr_data_out}, 16'hFFFF);
            else
                check("wr_strobe", {reg_wr_addr_out, reg_wr_data_out}, wr_q.pop_front());
        end
        if (mon_en) begin
            if (sda_oe_out) saw_oe = 1'b1;
            if (busy_out)   saw_busy = 1'b1;
        end
    end

    task automatic i2c_start();
        if (scl == 1'b0) begin
            #Q sda_drv = 1'b1;
            #Q scl = 1'b1;
        end
        #Q sda_drv = 1'b0;
        #Q scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #Q sda_drv = 1'b0;
        #Q scl = 1'b1;
        #Q sda_drv = 1'b1;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack);
        exp_t e;
        for (int i = 7; i >= 0; i--) begin
            #Q sda_drv = b[i];
            #Q scl = 1'b1;
            #(2*Q) scl = 1'b0;
        end
        e.tag = $sformatf("ack_%02h", b);
        e.val = 16'(exp_ack);
        exp_q.push_back(e);
        #Q sda_drv = 1'b1;
        #Q scl = 1'b1;
        #Q sb_pop(16'(sda_line));
        #Q scl = 1'b0;
    endtask

    task automatic read_byte(input logic [7:0] exp_b, input logic nack);
        exp_t       e;
        logic [7:0] b;
        b = 8'h00;
        e.tag = "rd_byte";
        e.val = 16'(exp_b);
        exp_q.push_back(e);
        for (int i = 0; i < 8; i++) begin
            #Q sda_drv = 1'b1;
            #Q scl = 1'b1;
            #Q b = {b[6:0], sda_line};
            #Q scl = 1'b0;
        end
        sb_pop(16'(b));
        #Q sda_drv = nack;
        #Q scl = 1'b1;
        #(2*Q) scl = 1'b0;
    endtask

    task automatic write_reg(input logic [7:0] addr, input logic [7:0] data, input logic strobe);
        i2c_start();
        write_byte(8'hB4, 1'b0);
        write_byte(addr, 1'b0);
        if (strobe) wr_q.push_back({addr, data});
        write_byte(data, 1'b0);
        i2c_stop();
    endtask

    task automatic read_seq(input logic [7:0] ptr, input int n, input logic [23:0] exp_bytes);
        i2c_start();
        write_byte(8'hB4, 1'b0);
        write_byte(ptr, 1'b0);
        i2c_start();
        write_byte(8'hB5, 1'b0);
        for (int k = 0; k < n; k++)
            read_byte(exp_bytes[23-8*k -: 8], (k == n - 1));
        i2c_stop();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (5) @(negedge clk_in);
        check("rst_sda_oe", 16'(sda_oe_out), 16'd0);
        rst_in = 1'b0;
        repeat (5) @(negedge clk_in);
        check("rst_busy",     16'(busy_out), 16'd0);
        check("rst_wr_valid", 16'(reg_wr_valid_out), 16'd0);
        check("rst_wr_addr",  16'(reg_wr_addr_out), 16'd0);
        check("rst_wr_data",  16'(reg_wr_data_out), 16'd0);
`ifdef MPR121_IRQ_EN
        check("rst_irq_n",    16'(irq_n_out), 16'd1);
`endif

        // Write then read back
        write_reg(8'h5E, 8'h8F, 1'b1);
        read_seq(8'h5E, 1, {8'h8F, 16'h0000});

        // Touch read with input changed mid-read
        touch_status_in = 12'hA53;
        i2c_start();
        write_byte(8'hB4, 1'b0);
        write_byte(8'h00, 1'b0);
        i2c_start();
        write_byte(8'hB5, 1'b0);
        read_byte(8'h53, 1'b0);
        touch_status_in = 12'h5AC;
        read_byte(8'h0A, 1'b1);
        i2c_stop();

        // Address mismatch
        i2c_start();
        saw_oe = 1'b0;
        saw_busy = 1'b0;
        mon_en = 1'b1;
        write_byte(8'hB6, 1'b1);
        mon_en = 1'b0;
        check("mismatch_sda_oe", 16'(saw_oe), 16'd0);
        check("mismatch_busy",   16'(saw_busy), 16'd0);
        i2c_stop();

        // Soft reset
        write_reg(8'h5C, 8'h77, 1'b1);
        read_seq(8'h5C, 1, {8'h77, 16'h0000});
        write_reg(8'h80, 8'h63, 1'b1);
        read_seq(8'h5C, 3, {8'h10, 8'h24, 8'h00});

        // Last in-range register, then an out-of-range write that must be discarded
        i2c_start();
        write_byte(8'hB4, 1'b0);
        write_byte(8'h7F, 1'b0);
        wr_q.push_back(16'h7F11);
        write_byte(8'h11, 1'b0);
        write_byte(8'h22, 1'b0);
        i2c_stop();
        read_seq(8'h7F, 2, {8'h11, 8'h00, 8'h00});

        // Pointer wrap 0xFF -> 0x00
        touch_status_in = 12'h3C7;
        read_seq(8'hFF, 2, {8'h00, 8'hC7, 8'h00});

        // Reset mid-read while the target drives a 0 bit (0x5D = 0x24, MSB 0)
        i2c_start();
        write_byte(8'hB4, 1'b0);
        write_byte(8'h5D, 1'b0);
        i2c_start();
        write_byte(8'hB5, 1'b0);
        for (int i = 0; i < 20 && !sda_oe_out; i++) @(negedge clk_in);
        check("rd_bit0_driven", 16'(sda_oe_out), 16'd1);
        #2 rst_in = 1'b1;
        #1;
        check("rst_mid_sda_oe", 16'(sda_oe_out), 16'd0);
        check("rst_mid_busy",   16'(busy_out), 16'd0);
        @(negedge clk_in);
        scl = 1'b1;
        sda_drv = 1'b1;
        repeat (5) @(negedge clk_in);
        rst_in = 1'b0;
        repeat (5) @(negedge clk_in);
        write_reg(8'h5E, 8'h3C, 1'b1);
        read_seq(8'h5E, 1, {8'h3C, 16'h0000});

        repeat (10) @(negedge clk_in);
        check("sb_drain", 16'(exp_q.size()), 16'd0);
        check("wr_drain", 16'(wr_q.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
